// File: rtl/snes_input_controller_if.sv
// ---------------------------------------------------------------------------
// snes_input_controller_if
//
// Bundles the gamepad wires and the decoded button outputs of
// snes_input_controller.
//
//   snes_data       pad -> controller, serial data, active-low (0 = pressed)
//   snes_latch      controller -> pad, latch strobe
//   snes_clk        controller -> pad, shift clock, idles high
//   buttons[11:0]   decoded pressed flags, 1 = pressed
//   controller_out  filtered 4-bit button code for the grid controller
//   frame_done      one-cycle pulse when a frame has been decoded
//
// master: the controller side.  slave: the pad / downstream consumer side.
// ---------------------------------------------------------------------------
interface snes_input_controller_if;
    logic        snes_data;
    logic        snes_latch;
    logic        snes_clk;
    logic [11:0] buttons;
    logic [3:0]  controller_out;
    logic        frame_done;

    modport master (
        input  snes_data,
        output snes_latch,
        output snes_clk,
        output buttons,
        output controller_out,
        output frame_done
    );

    modport slave (
        output snes_data,
        input  snes_latch,
        input  snes_clk,
        input  buttons,
        input  controller_out,
        input  frame_done
    );
endinterface

// File: rtl/snes_input_controller.sv
// ---------------------------------------------------------------------------
// snes_input_controller
//
// Polls a SNES-style serial gamepad every POLL_INTERVAL clocks, shifts in its
// 16-bit frame, and decodes it into a 4-bit button code for the grid
// controller.  The code only changes after two consecutive frames agree.
//
// Parameters
//   CLK_DIV        clk cycles per half-period of snes_clk (>= 4)
//   POLL_INTERVAL  clk cycles between frame starts (> 34*CLK_DIV + 2)
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   pad    snes_input_controller_if.master:
//            snes_data in, snes_latch / snes_clk to the pad,
//            buttons / controller_out / frame_done to the consumer
// ---------------------------------------------------------------------------
module snes_input_controller #(
    parameter int CLK_DIV       = 300,
    parameter int POLL_INTERVAL = 833333
) (
    input  logic                           clk,
    input  logic                           reset,
    snes_input_controller_if.master        pad
);

    localparam int POLL_W = $clog2(POLL_INTERVAL);
    localparam int DIV_W  = $clog2(2 * CLK_DIV);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_INTERVAL - 1);
    localparam logic [DIV_W-1:0]  LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  PHASE_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DECODE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [POLL_W-1:0] poll_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        bit_cnt;
    logic [15:0]       shift;
    logic [3:0]        prev_code;
    logic              data_meta;
    logic              data_s;

    logic              poll_wrap;
    logic              latch_end;
    logic              phase_end;
    logic              sig_ok;
    logic [11:0]       frame_btn;
    logic [3:0]        frame_code;

    // Lowest pressed index wins: scan from the top so lower bits overwrite.
    function automatic logic [3:0] encode(input logic [11:0] btn);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (btn[i]) begin
                code = 4'(i + 1);
            end
        end
        return code;
    endfunction

    // The pad line idles high, so the synchroniser resets to 1 to avoid a
    // spurious "pressed" sample straight out of reset.
    // NOTE: sequential state is updated with <= only, so every flop samples
    // the pre-edge value of every other flop regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            data_meta <= pad.snes_data;
            data_s    <= data_meta;
        end
    end

    // Free-running poll timer; its wrap is the only frame trigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end
    end

    assign poll_wrap = (poll_cnt == POLL_LAST);
    assign latch_end = (div_cnt == LATCH_LAST);
    assign phase_end = (div_cnt == PHASE_LAST);

    // The always-released signature bits must read as 0; otherwise the
    // frame is discarded and treated as "no buttons".
    assign sig_ok     = (shift[15:12] == 4'b0000);
    assign frame_btn  = sig_ok ? shift[11:0] : 12'h000;
    assign frame_code = encode(frame_btn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case, so no path through
    // this block leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (poll_wrap) next_state = LATCH;
            LATCH:    if (latch_end) next_state = CLK_LOW;
            CLK_LOW:  if (phase_end) next_state = CLK_HIGH;
            CLK_HIGH: begin
                if (phase_end) begin
                    next_state = (bit_cnt == 4'd15) ? DECODE : CLK_LOW;
                end
            end
            DECODE:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Datapath.  Pad strobes and frame_done are registered copies of the
    // next state so they line up exactly with the state register and reach
    // the pad pins glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt            <= '0;
            bit_cnt            <= 4'd0;
            shift              <= 16'h0000;
            prev_code          <= 4'd0;
            pad.buttons        <= 12'h000;
            pad.controller_out <= 4'd0;
            pad.snes_latch     <= 1'b0;
            pad.snes_clk       <= 1'b1;
            pad.frame_done     <= 1'b0;
        end else begin
            pad.snes_latch <= (next_state == LATCH);
            pad.snes_clk   <= (next_state != CLK_LOW);
            pad.frame_done <= (next_state == DECODE);

            // div_cnt times each phase from 0 on entry.
            if (next_state != state || state == IDLE || state == DECODE) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            case (state)
                LATCH: begin
                    if (latch_end) begin
                        shift[0] <= ~data_s;
                        bit_cnt  <= 4'd0;
                    end
                end
                CLK_HIGH: begin
                    // Sample late in the high phase, well after the pad has
                    // shifted on the rising edge and the synchroniser settled.
                    if (phase_end && bit_cnt != 4'd15) begin
                        shift[bit_cnt + 4'd1] <= ~data_s;
                        bit_cnt               <= bit_cnt + 4'd1;
                    end
                end
                DECODE: begin
                    pad.buttons <= frame_btn;
                    prev_code   <= frame_code;
                    // Two-frame agreement filter.
                    if (frame_code == prev_code) begin
                        pad.controller_out <= frame_code;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snes_input_controller.sv
// ---------------------------------------------------------------------------
// tb_snes_input_controller
//
// Directed bench for snes_input_controller with CLK_DIV=4, POLL_INTERVAL=200.
// A behavioural pad reloads on the latch rising edge and advances one bit on
// each snes_clk rising edge; pad_raw holds the raw (active-low) line levels.
// ---------------------------------------------------------------------------
module tb_snes_input_controller;

    localparam int CLK_DIV       = 4;
    localparam int POLL_INTERVAL = 200;

    logic clk;
    logic reset;

    snes_input_controller_if pad_if ();

    snes_input_controller #(
        .CLK_DIV       (CLK_DIV),
        .POLL_INTERVAL (POLL_INTERVAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pad_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- pad model ----------------
    logic [15:0] pad_raw = 16'hFFFF;
    logic [4:0]  pad_idx = 5'd16;

    always @(posedge pad_if.snes_latch) pad_idx = 5'd0;
    always @(posedge pad_if.snes_clk) begin
        if (!pad_if.snes_latch && !pad_idx[4]) pad_idx = pad_idx + 5'd1;
    end

    assign pad_if.snes_data = pad_idx[4] ? 1'b1 : pad_raw[pad_idx[3:0]];

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Counts rising clk edges after a reset release until snes_latch is seen.
    task automatic measure_latch_delay(input string tag);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (pad_if.snes_latch) break;
        end
        check(tag, cyc, POLL_INTERVAL);
    endtask

    // Waits (bounded) for frame_done, then steps one cycle so the decoded
    // outputs are visible, and checks frame_done was a single-cycle pulse.
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (pad_if.frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, seen, 1);
        @(posedge clk); #1;
        check({tag, "_pulse"}, pad_if.frame_done, 0);
    endtask

    task automatic frame_expect(input string tag, input logic [11:0] btn, input logic [3:0] code);
        wait_frame(tag);
        check({tag, "_buttons"}, pad_if.buttons, btn);
        check({tag, "_code"}, pad_if.controller_out, code);
    endtask

    initial begin
        int w;
        int low_run;
        int pulses;
        int bad_len;
        int falls;
        bit done_seen;
        bit prev_clk;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_latch", pad_if.snes_latch, 0);
        check("rst_clk", pad_if.snes_clk, 1);
        check("rst_buttons", pad_if.buttons, 0);
        check("rst_code", pad_if.controller_out, 0);
        check("rst_done", pad_if.frame_done, 0);
        @(negedge clk) reset = 1'b0;

        // ---- frame 1, pad released: strobe timing ----
        measure_latch_delay("latch_delay");
        w = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (pad_if.snes_latch) w++;
            else break;
        end
        check("latch_width", w, 2 * CLK_DIV);

        low_run = 0; pulses = 0; bad_len = 0; done_seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (pad_if.frame_done) begin
                done_seen = 1'b1;
                break;
            end
            if (!pad_if.snes_clk) low_run++;
            else if (low_run > 0) begin
                pulses++;
                if (low_run != CLK_DIV) bad_len++;
                low_run = 0;
            end
            @(posedge clk); #1;
        end
        check("frame1_done", done_seen, 1);
        check("clk_pulses", pulses, 16);
        check("clk_pulse_len_bad", bad_len, 0);
        @(posedge clk); #1;
        check("frame1_pulse", pad_if.frame_done, 0);
        check("frame1_buttons", pad_if.buttons, 0);
        check("frame1_code", pad_if.controller_out, 0);

        // ---- Right held two frames ----
        pad_raw = ~16'h0080;
        frame_expect("right1", 12'h080, 4'd0);
        frame_expect("right2", 12'h080, 4'd8);

        // ---- Left+Right, then release ----
        pad_raw = ~16'h00C0;
        frame_expect("lr1", 12'h0C0, 4'd8);
        frame_expect("lr2", 12'h0C0, 4'd7);
        pad_raw = 16'hFFFF;
        frame_expect("rel1", 12'h000, 4'd7);
        frame_expect("rel2", 12'h000, 4'd0);

        // ---- Start for one frame, then Left ----
        pad_raw = ~16'h0008;
        frame_expect("start1", 12'h008, 4'd0);
        pad_raw = ~16'h0040;
        frame_expect("left1", 12'h040, 4'd0);
        frame_expect("left2", 12'h040, 4'd7);

        // ---- bad signature (bit 13 low) plus Start ----
        pad_raw = ~16'h2008;
        frame_expect("sig1", 12'h000, 4'd7);
        frame_expect("sig2", 12'h000, 4'd0);

        // ---- reset mid-frame during CLK_LOW of bit 9 ----
        pad_raw = ~16'h0080;
        frame_expect("pre1", 12'h080, 4'd0);
        frame_expect("pre2", 12'h080, 4'd8);

        falls = 0; prev_clk = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (prev_clk && !pad_if.snes_clk) falls++;
            prev_clk = pad_if.snes_clk;
            if (falls == 10) break;
        end
        check("bit9_reached", falls, 10);
        @(posedge clk); #2;
        check("mid_clk_low", pad_if.snes_clk, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_clk", pad_if.snes_clk, 1);
        check("mid_rst_latch", pad_if.snes_latch, 0);
        check("mid_rst_buttons", pad_if.buttons, 0);
        check("mid_rst_code", pad_if.controller_out, 0);
        check("mid_rst_done", pad_if.frame_done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        measure_latch_delay("post_rst_latch_delay");
        frame_expect("post1", 12'h080, 4'd0);
        frame_expect("post2", 12'h080, 4'd8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/snes_input_controller.md
Name: snes_input_controller

Overview:
- Polls a SNES-style serial gamepad at a fixed rate and decodes its 16-bit shift-register frame into the 4-bit button code consumed by the grid controller's controller_in port.
- Generates the pad's latch and clock strobes, synchronises the pad data line, and applies a two-frame stability filter.
- Sits directly upstream of the grid controller in the top level.

Parameters:
- CLK_DIV, 300, clk cycles per half-period of snes_clk (6 us at 50 MHz); minimum 4.
- POLL_INTERVAL, 833333, clk cycles between frame starts (60 Hz at 50 MHz); must exceed 34*CLK_DIV+2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- snes_data  input  1  serial data from pad, active-low (0 = pressed)
- snes_latch  output  1  latch strobe to pad
- snes_clk  output  1  shift clock to pad, idles high
- buttons  output  12  decoded pressed flags, bit k = frame bit k (B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R), 1 = pressed
- controller_out  output  4  filtered button code: 0 = none, otherwise (lowest pressed bit index)+1 (Start=4, Left=7, Right=8)
- frame_done  output  1  one-cycle pulse when a frame has been decoded

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset. All flops clear immediately on reset assertion, including when reset asserts mid-frame.
- Reset values:
  - snes_latch=0, snes_clk=1, buttons=0, controller_out=0, frame_done=0.
  - Internal: state=IDLE, poll_cnt=0, div_cnt=0, bit_cnt=0, shift=0, prev_code=0, both synchroniser flops=1.
- Synchroniser: snes_data passes through a 2-flop synchroniser (data_s). All sampling uses data_s.
- poll_cnt counts 0..POLL_INTERVAL-1 and wraps, free-running in every state. The first frame starts POLL_INTERVAL cycles after reset deasserts.
- State machine: IDLE, LATCH, CLK_LOW, CLK_HIGH, DECODE.
  - IDLE: snes_latch=0, snes_clk=1. When poll_cnt==POLL_INTERVAL-1, go to LATCH with div_cnt=0.
  - LATCH: snes_latch=1 for 2*CLK_DIV cycles. In the last cycle, shift bit 0 <= ~data_s, then go to CLK_LOW with bit_cnt=0.
  - CLK_LOW: snes_clk=0 for CLK_DIV cycles, then go to CLK_HIGH.
  - CLK_HIGH: snes_clk=1 for CLK_DIV cycles. On the last cycle:
    - if bit_cnt<15: shift[bit_cnt+1] <= ~data_s, bit_cnt++, go to CLK_LOW;
    - if bit_cnt==15: go to DECODE.
  - DECODE (1 cycle):
    - Compute code from shift[11:0].
    - buttons <= shift[11:0].
    - controller_out <= code only if code==prev_code; otherwise it holds.
    - prev_code <= code.
    - frame_done=1 for this cycle only.
    - Go to IDLE.
- Frame timing: 16 snes_clk low pulses per frame. Frame length from LATCH entry to DECODE is 34*CLK_DIV cycles.
- Signature check: shift[15:12] are the pad's always-released bits and must decode as 0 (raw line high). If any is 1 (raw low), the frame is invalid:
  - buttons <= 0 and code is treated as 0;
  - an unplugged pad with pulled-up data reads all zeros, i.e. no buttons.
- Priority: with multiple buttons pressed, the lowest bit index wins. Example: Left+Right gives 7.
- controller_out changes only in DECODE. A new value needs two consecutive frames with the same code, so press/release latency is 2 frames.
- The poll_cnt wrap is never missed. POLL_INTERVAL exceeds frame length, so the FSM is always back in IDLE before the next wrap.

Test Plan (CLK_DIV=4, POLL_INTERVAL=200):
- Reset, pad model drives all-high -> snes_latch rises 200 cycles after reset release and stays high 8 cycles; exactly 16 snes_clk low pulses of 4 cycles each; frame_done pulses; buttons=0, controller_out=0.
- Pad holds Right (bit 7 low) for two frames -> after frame 1, buttons=12'h080 and controller_out=0; after frame 2, controller_out=8.
- Left+Right held (bits 6,7 low) for two frames -> controller_out=7, buttons=12'h0C0. Then release all for two frames -> controller_out=0 after the second release frame.
- Start held one frame, then Left for two frames -> controller_out never shows 4 and becomes 7 after the second Left frame.
- Pad drives bit 13 low plus Start low for two frames -> buttons=0, controller_out=0 (invalid signature).
- Reset asserted during CLK_LOW of bit 9 -> all outputs immediately at reset values, snes_clk=1. After release, the next latch occurs 200 cycles later and decodes correctly.
